// File: rtl/tlc_pkg.sv
// tlc_pkg
// Shared encodings for the traffic-light controller slice.
//   light_t        : farm/highway light colour (RED, YELLOW, GREEN)
//   sensor_state_t : farm sensor conditioner state, also driven out on Dbg
//   CNT_W          : width of the debounce and stuck-detector counters
package tlc_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    QUALIFY = 2'b01,
    REQUEST = 2'b10,
    SERVING = 2'b11
  } sensor_state_t;

  localparam int CNT_W = 31;

endpackage

// File: rtl/synchronizer.sv
// synchronizer
// Plain two-flop synchronizer for a single asynchronous bit. The flops carry
// no reset; callers that need a clean value after reset gate the input and
// mask the output themselves.
// Ports:
//   Clk : destination clock
//   d   : asynchronous input bit
//   q   : synchronized output, two Clk edges after d is sampled
module synchronizer (
  input  logic Clk,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/farm_sensor_conditioner.sv
// farm_sensor_conditioner
// Cleans up the farm-road vehicle detector for tlc_controller: synchronizes
// the raw input, debounces it, latches a qualified call until the farm road
// goes green, passes live presence through while green, and falls back to
// permanent recall when the detector appears stuck at "present".
// Ports:
//   Clk        : system clock
//   Rst        : synchronous reset, active low
//   SensorRaw  : asynchronous raw detector, 1 = vehicle present
//   farmSignal : current farm light from the controller (light_t encoding)
//   farmSensor : conditioned vehicle call to the controller
//   Fault      : sticky stuck-detector flag, cleared only by reset
//   Dbg        : current state encoding
module farm_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int STUCK_CYCLES    = 1_500_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SensorRaw,
  input  logic [1:0] farmSignal,
  output logic       farmSensor,
  output logic       Fault,
  output logic [1:0] Dbg
);

  localparam logic [CNT_W-1:0] QLAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLAST   = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SMAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             rawgated;
  logic             syncq;
  logic             armed;
  logic             sync;
  logic             green;
  sensor_state_t    state;
  sensor_state_t    nextstate;
  logic [CNT_W-1:0] qcnt;
  logic [CNT_W-1:0] scnt;

  // The synchronizer has no reset. Gating its input clears the first flop on
  // a reset edge; armed masks the second flop for the one cycle it still
  // holds pre-reset data, so sync reads 0 immediately after reset.
  assign rawgated = SensorRaw & Rst;

  synchronizer u_sync (
    .Clk (Clk),
    .d   (rawgated),
    .q   (syncq)
  );

  always_ff @(posedge Clk) begin
    armed <= Rst;
  end

  assign sync  = syncq & armed;
  assign green = (farmSignal == GREEN);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= nextstate;
    end
  end

  // REQUEST ignores sync so a vehicle that left after qualifying is still
  // served; GREEN is only acted on from REQUEST and SERVING.
  always_comb begin
    nextstate = state;
    case (state)
      IDLE:    if (sync) nextstate = QUALIFY;
      QUALIFY: begin
        if (!sync) begin
          nextstate = IDLE;
        end else if (qcnt == QLAST) begin
          nextstate = REQUEST;
        end
      end
      REQUEST: if (green) nextstate = SERVING;
      SERVING: if (!green) nextstate = IDLE;
      default: nextstate = IDLE;
    endcase
  end

  // Holding qcnt at zero in IDLE makes every entry into QUALIFY start a full
  // qualification, which is what rejects single-cycle low glitches.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      qcnt <= '0;
    end else if (state == IDLE) begin
      qcnt <= '0;
    end else if (state == QUALIFY && sync && qcnt != QLAST) begin
      qcnt <= qcnt + CNT_ONE;
    end
  end

  // Fault is set on the same edge that scnt reaches STUCK_CYCLES, so it is
  // compared against the pre-increment value.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      scnt  <= '0;
      Fault <= 1'b0;
    end else begin
      if (!sync) begin
        scnt <= '0;
      end else if (scnt != SMAX) begin
        scnt <= scnt + CNT_ONE;
      end
      if (sync && scnt == SLAST) begin
        Fault <= 1'b1;
      end
    end
  end

  always_comb begin
    farmSensor = 1'b0;
    case (state)
      REQUEST: farmSensor = 1'b1;
      SERVING: farmSensor = sync;
      default: farmSensor = 1'b0;
    endcase
    if (Fault) begin
      farmSensor = 1'b1;
    end
  end

  assign Dbg = state;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// tb_farm_sensor_conditioner
// Directed bench for farm_sensor_conditioner with DEBOUNCE_CYCLES = 4 and
// STUCK_CYCLES = 20. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, so "after edge N" means the value
// seen once edge N has been taken.
module tb_farm_sensor_conditioner;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;

  logic       Clk;
  logic       Rst;
  logic       SensorRaw;
  logic [1:0] farmSignal;
  logic       farmSensor;
  logic       Fault;
  logic [1:0] Dbg;

  int assertCount;
  int failCount;

  farm_sensor_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .STUCK_CYCLES    (20)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .SensorRaw  (SensorRaw),
    .farmSignal (farmSignal),
    .farmSensor (farmSensor),
    .Fault      (Fault),
    .Dbg        (Dbg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic applyStimulus(input logic raw, input logic [1:0] light, input int edges);
    SensorRaw  = raw;
    farmSignal = light;
    repeat (edges) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    Rst         = 1'b0;
    SensorRaw   = 1'b0;
    farmSignal  = L_RED;

    // Power-on reset
    applyStimulus(0, L_RED, 3);
    checkOutput("reset_farmSensor", farmSensor, 0);
    checkOutput("reset_fault", Fault, 0);
    checkOutput("reset_dbg", Dbg, 0);
    Rst = 1'b1;

    // Qualified call: raw high from edge 1, call appears after edge 7
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1, L_RED, 1);
      checkOutput("qual_hold_low", farmSensor, 0);
    end
    checkOutput("qual_dbg_e6", Dbg, 1);
    applyStimulus(1, L_RED, 1);
    checkOutput("qual_farmSensor_e7", farmSensor, 1);
    checkOutput("qual_dbg_e7", Dbg, 2);

    // Latch and serve
    applyStimulus(0, L_RED, 10);
    checkOutput("latch_farmSensor", farmSensor, 1);
    checkOutput("latch_dbg", Dbg, 2);
    applyStimulus(0, L_GREEN, 1);
    checkOutput("serve_dbg", Dbg, 3);
    checkOutput("serve_absent", farmSensor, 0);
    applyStimulus(1, L_GREEN, 1);
    checkOutput("serve_lag1", farmSensor, 0);
    applyStimulus(1, L_GREEN, 1);
    checkOutput("serve_present", farmSensor, 1);
    applyStimulus(1, L_YELLOW, 1);
    checkOutput("yellow_dbg", Dbg, 0);
    checkOutput("yellow_farmSensor", farmSensor, 0);
    applyStimulus(0, L_RED, 4);
    checkOutput("settle1_dbg", Dbg, 0);

    // Glitch rejection: low at edge 4, qualification restarts, call after edge 11
    for (int e = 1; e <= 10; e++) begin
      applyStimulus((e == 4) ? 1'b0 : 1'b1, L_RED, 1);
      checkOutput("glitch_hold_low", farmSensor, 0);
    end
    applyStimulus(1, L_RED, 1);
    checkOutput("glitch_farmSensor_e11", farmSensor, 1);
    checkOutput("glitch_dbg_e11", Dbg, 2);
    applyStimulus(0, L_GREEN, 1);
    checkOutput("glitch_serve_dbg", Dbg, 3);
    applyStimulus(0, L_RED, 1);
    checkOutput("leave_green_dbg", Dbg, 0);
    checkOutput("leave_green_farmSensor", farmSensor, 0);
    applyStimulus(0, L_RED, 4);
    checkOutput("settle2_dbg", Dbg, 0);

    // Simultaneous GREEN: ignored in IDLE/QUALIFY, REQUEST at 7, SERVING at 8
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1, L_GREEN, 1);
      checkOutput("simul_dbg_early", Dbg, (e >= 3) ? 1 : 0);
    end
    applyStimulus(1, L_GREEN, 1);
    checkOutput("simul_dbg_e7", Dbg, 2);
    applyStimulus(1, L_GREEN, 1);
    checkOutput("simul_dbg_e8", Dbg, 3);
    checkOutput("simul_farmSensor_e8", farmSensor, 1);
    applyStimulus(0, L_RED, 4);
    checkOutput("settle3_dbg", Dbg, 0);

    // Reset in the middle of qualification
    applyStimulus(1, L_RED, 4);
    checkOutput("preqrst_dbg", Dbg, 1);
    Rst = 1'b0;
    applyStimulus(1, L_RED, 1);
    checkOutput("qrst_farmSensor", farmSensor, 0);
    checkOutput("qrst_fault", Fault, 0);
    checkOutput("qrst_dbg", Dbg, 0);
    Rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1, L_RED, 1);
      checkOutput("requal_hold_low", farmSensor, 0);
    end
    checkOutput("requal_dbg_e6", Dbg, 1);
    applyStimulus(1, L_RED, 1);
    checkOutput("requal_farmSensor_e7", farmSensor, 1);

    // Stuck detector: raw stays high, light cycles RED -> GREEN -> RED
    applyStimulus(1, L_GREEN, 5);
    checkOutput("stuck_serving_dbg", Dbg, 3);
    checkOutput("stuck_serving_fault", Fault, 0);
    applyStimulus(1, L_RED, 1);
    checkOutput("stuck_idle_dbg", Dbg, 0);
    checkOutput("stuck_idle_farmSensor", farmSensor, 0);
    applyStimulus(1, L_RED, 8);
    checkOutput("stuck_fault_e21", Fault, 0);
    checkOutput("stuck_dbg_e21", Dbg, 2);
    applyStimulus(1, L_RED, 1);
    checkOutput("stuck_fault_e22", Fault, 1);
    checkOutput("stuck_farmSensor_e22", farmSensor, 1);
    applyStimulus(1, L_GREEN, 1);
    checkOutput("fault_serving_dbg", Dbg, 3);
    checkOutput("fault_serving_farmSensor", farmSensor, 1);
    applyStimulus(1, L_RED, 1);
    checkOutput("fault_idle_dbg", Dbg, 0);
    checkOutput("fault_idle_farmSensor", farmSensor, 1);
    applyStimulus(1, L_RED, 1);
    checkOutput("fault_qualify_dbg", Dbg, 1);
    checkOutput("fault_qualify_farmSensor", farmSensor, 1);
    applyStimulus(0, L_RED, 5);
    checkOutput("fault_sticky", Fault, 1);
    checkOutput("fault_recall_farmSensor", farmSensor, 1);
    checkOutput("fault_settle_dbg", Dbg, 0);

    // Reset clears the fault
    Rst = 1'b0;
    applyStimulus(0, L_RED, 1);
    checkOutput("frst_farmSensor", farmSensor, 0);
    checkOutput("frst_fault", Fault, 0);
    checkOutput("frst_dbg", Dbg, 0);
    Rst = 1'b1;
    applyStimulus(0, L_RED, 3);
    checkOutput("post_frst_fault", Fault, 0);
    checkOutput("post_frst_farmSensor", farmSensor, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/farm_sensor_conditioner.md
# farm_sensor_conditioner

Conditions the raw farm-road vehicle detector before it reaches the traffic-light controller. It synchronizes the asynchronous sensor input, debounces it, and latches a qualified vehicle call until the farm road is served. While the farm light is green it passes live presence through, so the controller can extend the green. It also flags a detector stuck at "present" and falls back to permanent recall. It sits directly upstream of `tlc_controller`, and its `farmSensor` output drives that block's `farmSensor` input.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles of continuous presence (10 ms at 100 MHz) needed to qualify a call; legal range ≥ 2.
- `STUCK_CYCLES`, default 1_500_000_000: continuous-presence cycles after which the detector is declared stuck; must exceed `DEBOUNCE_CYCLES` and be < 2^31.
- `Clk`  in  1  system clock; the only clock.
- `Rst`  in  1  reset, synchronous, active-low.
- `SensorRaw`  in  1  raw detector output; asynchronous; 1 = vehicle present.
- `farmSignal`  in  2  current farm light, from the controller.
- `farmSensor`  out  1  conditioned vehicle call to the controller.
- `Fault`  out  1  sticky stuck-detector flag.
- `Dbg`  out  2  current state encoding, for the debug header.

## Operation
- **Synchronizer.** A 2-flop synchronizer on `SensorRaw` produces `sync`; all logic uses `sync` only.
- **States.** IDLE = 0, QUALIFY = 1, REQUEST = 2, SERVING = 3. `Dbg` = state.
- **Debounce counter.** `qcnt` is a 31-bit counter.
- **IDLE**
  - `sync` = 1 → QUALIFY, with `qcnt` ← 0.
- **QUALIFY**
  - `sync` = 0 → IDLE.
  - Otherwise, if `qcnt` == `DEBOUNCE_CYCLES`−1 → REQUEST.
  - Otherwise `qcnt` increments.
- **REQUEST**
  - Holds regardless of `sync`, so a vehicle that leaves after qualifying is still served.
  - `farmSignal` == GREEN → SERVING.
- **SERVING**
  - `farmSignal` != GREEN → IDLE.
- **farmSensor**
  - IDLE and QUALIFY: 0.
  - REQUEST: 1.
  - SERVING: equals `sync`.
  - When `Fault` = 1: forced to 1 in every state (recall mode).
- **Stuck detection**
  - `scnt` is a 31-bit saturating counter.
  - Cleared whenever `sync` = 0; increments while `sync` = 1.
  - When `scnt` reaches `STUCK_CYCLES`, `Fault` ← 1.
  - `Fault` is cleared only by reset.
- **Simultaneous events**
  - GREEN arriving in the same cycle QUALIFY completes: go to REQUEST; SERVING is entered on the next cycle if GREEN is still present.
  - GREEN while in IDLE or QUALIFY is ignored.
- **Reset** (Rst = 0 at a rising edge, any state, mid-qualify included):
  - State = IDLE; `qcnt`, `scnt`, sync flops and `Fault` = 0.
  - Resulting outputs: `farmSensor` = 0, `Fault` = 0, `Dbg` = 0.

## Timing
- All outputs are driven from registers or a pure decode of registers. There is no combinational path from `SensorRaw` or `farmSignal` to any output.
- Synchronizer latency is 2 cycles.
- `SensorRaw` rises and stays high (sampled high from edge 1) → `farmSensor` rises after edge `DEBOUNCE_CYCLES`+3.
  - Example: D = 4 → high after edge 7.
- A low glitch of one cycle on `sync` in QUALIFY restarts qualification in full.
- `farmSignal` changes to GREEN in REQUEST → state = SERVING one edge later.
- In SERVING, `farmSensor` follows `SensorRaw` with 2-cycle latency.
- Farm light leaves GREEN → IDLE one edge later; `farmSensor` = 0 from that edge unless `Fault` = 1.
- Continuous presence from edge 1 → `Fault` rises after edge `STUCK_CYCLES`+2.

## Structure
- Shared package `tlc_pkg` contains:
  - Light encoding: RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10.
  - Sensor state encoding: IDLE, QUALIFY, REQUEST, SERVING.
- `tlc_fsm` imports the same light encoding.
- The 2-flop synchronizer is the existing `synchronizer` module, reused unchanged as the one sub-module. Its output flops are not reset by `Rst`; an explicit synchronous clear of `sync` flops is done locally by gating.
- Counters and state live in this module.

## Test plan
All tests use `DEBOUNCE_CYCLES` = 4 and `STUCK_CYCLES` = 20.
- **Qualified call.** Raw high from edge 1, `farmSignal` = RED → `farmSensor` 0 through edge 6, 1 after edge 7, `Dbg` = 2.
- **Glitch rejection.** Raw high 3 cycles, low 1, high again → `farmSensor` stays 0 until a full 4-cycle qualification completes after the final rise.
- **Latch and serve.** Qualify, then raw low, hold RED 10 cycles → `farmSensor` stays 1.
  - Drive GREEN → `Dbg` = 3 next edge, `farmSensor` = 0 (`sync` low).
  - Raw high → `farmSensor` 1 two edges later.
  - Drive YELLOW → `Dbg` = 0 and `farmSensor` = 0 next edge.
- **Stuck detector.** Raw held high throughout, with `farmSignal` cycling RED → GREEN → RED → `Fault` = 1 after edge 22 and `farmSensor` = 1 thereafter in all states.
  - Raw low → `Fault` stays 1.
- **Reset.** Rst = 0 for one edge in QUALIFY and again with `Fault` = 1 → all outputs 0 next edge; qualification restarts from 0.
- **Simultaneous GREEN.** GREEN asserted in the same cycle qualification completes → `Dbg` = 2, then 3 one edge later.
